ex_operand_stage: RTL and testbench

// - ID/EX pipeline register plus EX-stage operand selection; directly upstream of the ALU.
// - Latches decoded instruction fields at each clock edge.
// - Resolves RAW hazards by forwarding from the MEM and WB stages, then presents ALU A, B and op.
// - Passes store data and write-back control down to EX/MEM.

---
 rtl/ex_operand_stage_pkg.sv | 18 +
 rtl/ex_operand_stage_fwd_mux.sv | 49 ++++
 rtl/ex_operand_stage.sv | 120 ++++++++++++
 tb/tb_ex_operand_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the EX operand stage: ALU opcodes, the bubble opcode
// and the forwarding source select.
package ex_operand_stage_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ORI    = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_BUBBLE = ALU_ADD;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: MEM result beats WB result beats registered GRF data.
// Forwarding is only active when FWD_EN is defined; otherwise reg_data passes through.
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic [RA_W-1:0]  addr,
  input  logic [WIDTH-1:0] reg_data,
  input  logic             mem_we,
  input  logic [RA_W-1:0]  mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] data
);

  fwd_sel_t sel;

`ifdef FWD_EN
  // $0 is hard-wired zero, so a producer targeting it is never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (addr != '0) begin
      if (mem_we && (mem_addr == addr)) begin
        sel = FWD_MEM;
      end else if (wb_we && (wb_addr == addr)) begin
        sel = FWD_WB;
      end
    end
  end
`else
  logic unused_fwd;
  assign sel        = FWD_REG;
  assign unused_fwd = ^{addr, mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data};
`endif

  always_comb begin
    data = reg_data;
    case (sel)
      FWD_MEM: data = mem_data;
      FWD_WB:  data = wb_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand selection feeding the ALU.
// Define FWD_EN to enable MEM/WB forwarding; without it operands come from registered GRF data.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm32,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic [OP_W-1:0]  id_alu_op,
  input  logic             id_alu_src_imm,
  input  logic             id_reg_we,
  input  logic             id_mem_we,
  input  logic             id_mem_to_reg,
  input  logic             mem_reg_we,
  input  logic [RA_W-1:0]  mem_rd_addr,
  input  logic [WIDTH-1:0] mem_fwd_data,
  input  logic             wb_reg_we,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic [WIDTH-1:0] wb_fwd_data,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_alu_a,
  output logic [WIDTH-1:0] ex_alu_b,
  output logic [OP_W-1:0]  ex_alu_op,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA_W-1:0]  ex_rd_addr,
  output logic             ex_reg_we,
  output logic             ex_mem_we,
  output logic             ex_mem_to_reg
);

  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic [RA_W-1:0]  rs_addr;
  logic [RA_W-1:0]  rt_addr;
  logic             alu_src_imm;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;
  logic             load_bubble;

  // A non-stalled edge with no real ID instruction is treated like a flush.
  assign load_bubble = reset || flush_i || (!stall_i && !id_valid);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      rs_data       <= '0;
      rt_data       <= '0;
      imm           <= '0;
      rs_addr       <= '0;
      rt_addr       <= '0;
      ex_rd_addr    <= '0;
      ex_alu_op     <= OP_W'(ALU_BUBBLE);
      alu_src_imm   <= 1'b0;
      ex_reg_we     <= 1'b0;
      ex_mem_we     <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!stall_i) begin
      ex_valid      <= 1'b1;
      ex_pc         <= id_pc;
      rs_data       <= id_rs_data;
      rt_data       <= id_rt_data;
      imm           <= id_imm32;
      rs_addr       <= id_rs_addr;
      rt_addr       <= id_rt_addr;
      ex_rd_addr    <= id_rd_addr;
      ex_alu_op     <= id_alu_op;
      alu_src_imm   <= id_alu_src_imm;
      ex_reg_we     <= id_reg_we;
      ex_mem_we     <= id_mem_we;
      ex_mem_to_reg <= id_mem_to_reg;
    end
  end

  // Forwarding keeps evaluating on held addresses so a stalled instruction
  // picks up producer results as they move down the pipe.
  ex_operand_stage_fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs (
    .addr     (rs_addr),
    .reg_data (rs_data),
    .mem_we   (mem_reg_we),
    .mem_addr (mem_rd_addr),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_reg_we),
    .wb_addr  (wb_rd_addr),
    .wb_data  (wb_fwd_data),
    .data     (fwd_rs)
  );

  ex_operand_stage_fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rt (
    .addr     (rt_addr),
    .reg_data (rt_data),
    .mem_we   (mem_reg_we),
    .mem_addr (mem_rd_addr),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_reg_we),
    .wb_addr  (wb_rd_addr),
    .wb_data  (wb_fwd_data),
    .data     (fwd_rt)
  );

  assign ex_alu_a      = fwd_rs;
  assign ex_alu_b      = alu_src_imm ? imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed cases then randomized
// traffic against a record-level reference model.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm32;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [4:0]  id_rd_addr;
  logic [2:0]  id_alu_op;
  logic        id_alu_src_imm;
  logic        id_reg_we;
  logic        id_mem_we;
  logic        id_mem_to_reg;
  logic        mem_reg_we;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_fwd_data;
  logic        wb_reg_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_fwd_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we;
  logic        ex_mem_we;
  logic        ex_mem_to_reg;

  int tests = 0;
  int fails = 0;

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  op;
    logic        src_imm;
    logic        reg_we;
    logic        mem_we;
    logic        mem_to_reg;
  } ex_rec_t;

  ex_rec_t m;

  ex_operand_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm32       (id_imm32),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rd_addr     (id_rd_addr),
    .id_alu_op      (id_alu_op),
    .id_alu_src_imm (id_alu_src_imm),
    .id_reg_we      (id_reg_we),
    .id_mem_we      (id_mem_we),
    .id_mem_to_reg  (id_mem_to_reg),
    .mem_reg_we     (mem_reg_we),
    .mem_rd_addr    (mem_rd_addr),
    .mem_fwd_data   (mem_fwd_data),
    .wb_reg_we      (wb_reg_we),
    .wb_rd_addr     (wb_rd_addr),
    .wb_fwd_data    (wb_fwd_data),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_alu_a       (ex_alu_a),
    .ex_alu_b       (ex_alu_b),
    .ex_alu_op      (ex_alu_op),
    .ex_store_data  (ex_store_data),
    .ex_rd_addr     (ex_rd_addr),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_we      (ex_mem_we),
    .ex_mem_to_reg  (ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_rec_t bubble();
    ex_rec_t b;
    b    = '0;
    b.op = ALU_ADD;
    return b;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    logic hit_mem;
    logic hit_wb;
    hit_mem = (a != 5'd0) && mem_reg_we && (mem_rd_addr == a);
    hit_wb  = (a != 5'd0) && wb_reg_we && (wb_rd_addr == a);
    if (FWD && hit_mem) return mem_fwd_data;
    if (FWD && hit_wb) return wb_fwd_data;
    return d;
  endfunction

  task automatic model_update();
    if (reset || flush_i) begin
      m = bubble();
    end else if (!stall_i) begin
      if (!id_valid) begin
        m = bubble();
      end else begin
        m.valid      = 1'b1;
        m.pc         = id_pc;
        m.rs_data    = id_rs_data;
        m.rt_data    = id_rt_data;
        m.imm        = id_imm32;
        m.rs_addr    = id_rs_addr;
        m.rt_addr    = id_rt_addr;
        m.rd_addr    = id_rd_addr;
        m.op         = id_alu_op;
        m.src_imm    = id_alu_src_imm;
        m.reg_we     = id_reg_we;
        m.mem_we     = id_mem_we;
        m.mem_to_reg = id_mem_to_reg;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_a;
    logic [31:0] exp_rt;
    exp_a  = fwd(m.rs_addr, m.rs_data);
    exp_rt = fwd(m.rt_addr, m.rt_data);
    chk(tag, "valid",      {31'd0, ex_valid},      {31'd0, m.valid});
    chk(tag, "pc",         ex_pc,                  m.pc);
    chk(tag, "alu_a",      ex_alu_a,               exp_a);
    chk(tag, "alu_b",      ex_alu_b,               m.src_imm ? m.imm : exp_rt);
    chk(tag, "alu_op",     {29'd0, ex_alu_op},     {29'd0, m.op});
    chk(tag, "store_data", ex_store_data,          exp_rt);
    chk(tag, "rd_addr",    {27'd0, ex_rd_addr},    {27'd0, m.rd_addr});
    chk(tag, "reg_we",     {31'd0, ex_reg_we},     {31'd0, m.reg_we});
    chk(tag, "mem_we",     {31'd0, ex_mem_we},     {31'd0, m.mem_we});
    chk(tag, "mem_to_reg", {31'd0, ex_mem_to_reg}, {31'd0, m.mem_to_reg});
  endtask

  task automatic set_ctrl(input logic rst, input logic stl, input logic fl);
    reset   = rst;
    stall_i = stl;
    flush_i = fl;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
    mem_reg_we   = mwe;
    mem_rd_addr  = mrd;
    mem_fwd_data = md;
    wb_reg_we    = wwe;
    wb_rd_addr   = wrd;
    wb_fwd_data  = wd;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                          input logic [31:0] rsd, input logic [4:0] rt,
                          input logic [31:0] rtd, input logic [31:0] im,
                          input logic [4:0] rd, input logic [2:0] op, input logic src,
                          input logic rwe, input logic mwe, input logic m2r);
    id_valid       = v;
    id_pc          = pc;
    id_rs_addr     = rs;
    id_rs_data     = rsd;
    id_rt_addr     = rt;
    id_rt_data     = rtd;
    id_imm32       = im;
    id_rd_addr     = rd;
    id_alu_op      = op;
    id_alu_src_imm = src;
    id_reg_we      = rwe;
    id_mem_we      = mwe;
    id_mem_to_reg  = m2r;
  endtask

  task automatic drive_id_random();
    drive_id(1'b1, $urandom, 5'($urandom_range(0, 3)), $urandom,
             5'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 7)),
             3'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
  endtask

  initial begin
    m = bubble();
    set_ctrl(1'b1, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, ALU_ADD,
             1'b0, 1'b0, 1'b0, 1'b0);

    // Reset for one cycle, then every output must be the bubble.
    tick();
    set_ctrl(1'b0, 1'b0, 1'b0);
    #1 check_all("reset");
    chk("reset", "alu_op_add", {29'd0, ex_alu_op}, {29'd0, ALU_ADD});

    // ori with rs=$1 (0x10), imm 0xFF, no producers in flight.
    drive_id(1'b1, 32'h100, 5'd1, 32'h10, 5'd2, 32'h22, 32'hFF, 5'd4, ALU_ORI,
             1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #1 check_all("ori");
    chk("ori", "a_const", ex_alu_a, 32'h10);
    chk("ori", "b_const", ex_alu_b, 32'hFF);

    // rs=$3 with both MEM and WB targeting $3: MEM must win.
    drive_id(1'b1, 32'h104, 5'd3, 32'h33, 5'd2, 32'h44, 32'h0, 5'd5, ALU_ADD,
             1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    #1 check_all("mem_prio");
    set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    #1 check_all("wb_only");

    // Store with rt=$0 while MEM writes $0: no forwarding onto $0.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 32'h108, 5'd1, 32'h11, 5'd0, 32'h0, 32'h8, 5'd0, ALU_ADD,
             1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    #1 check_all("rt_zero");
    chk("rt_zero", "store_const", ex_store_data, 32'h0);

    // Load rs=$5, then stall two cycles while ID churns; WB hits $5 in cycle 2.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 32'h10C, 5'd5, 32'h123, 5'd6, 32'h456, 32'h0, 5'd7, ALU_SUB,
             1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0);
    drive_id_random();
    #1 check_all("stall1");
    chk("stall1", "a_const", ex_alu_a, 32'h123);
    tick();
    drive_id_random();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hBEEF);
    #1 check_all("stall2");
    chk("stall2", "pc_hold", ex_pc, 32'h10C);

    // Stall and flush together: flush wins and a bubble arrives.
    set_ctrl(1'b0, 1'b1, 1'b1);
    tick();
    set_ctrl(1'b0, 1'b0, 1'b0);
    set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
    #1 check_all("stall_flush");
    chk("stall_flush", "a_zero", ex_alu_a, 32'h0);
    chk("stall_flush", "b_zero", ex_alu_b, 32'h0);

    // Reset asserted mid-stall also yields a bubble.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id_random();
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0);
    tick();
    set_ctrl(1'b1, 1'b1, 1'b0);
    tick();
    set_ctrl(1'b0, 1'b0, 1'b0);
    #1 check_all("reset_stall");

    // id_valid low on a normal edge loads a bubble.
    drive_id_random();
    tick();
    drive_id_random();
    id_valid = 1'b0;
    tick();
    #1 check_all("id_invalid");

    // Randomized traffic with narrow address ranges to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_ctrl(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0));
      drive_id_random();
      id_valid = ($urandom_range(0, 7) != 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      #1 check_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
